// File: rtl/ripple_pkg.sv
// Shared definitions for the ripple counter chain sequencer: state encoding
// and counter widths used by the controller and its match filter.
package ripple_pkg;

  localparam int RUN_CNT_W = 8;
  localparam int CYC_CNT_W = 4;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CLR  = 3'd1;
  localparam logic [2:0] RUN  = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

endpackage

// File: rtl/ripple_match_filter.sv
// Two-stage sampler of the asynchronous chain outputs. A match is reported
// only when two consecutive samples both equal the limit, rejecting ripple glitches.
module ripple_match_filter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             flush,
  input  logic [WIDTH-1:0] count_in,
  input  logic [WIDTH-1:0] lim,
  output logic             match
);

  logic [WIDTH-1:0] samp0_r;
  logic [WIDTH-1:0] samp1_r;
  logic [1:0]       vld_r;

  // sampler pipeline; flush empties it so stale samples never compare equal
  always_ff @(posedge clk) begin
    if (clear) begin
      samp0_r <= {WIDTH{1'b0}};
      samp1_r <= {WIDTH{1'b0}};
      vld_r   <= 2'b00;
    end else if (flush) begin
      samp0_r <= {WIDTH{1'b0}};
      samp1_r <= {WIDTH{1'b0}};
      vld_r   <= 2'b00;
    end else begin
      samp0_r <= count_in;
      samp1_r <= samp0_r;
      vld_r   <= {vld_r[0], 1'b1};
    end
  end

  assign match = (vld_r == 2'b11) && (samp0_r == lim) && (samp1_r == lim);

endmodule

// File: rtl/ripple_chain_ctrl.sv
// Sequencer for the JK toggle ripple counter chain: clears the chain, runs it
// until the programmed limit is seen (or the run budget expires), settles and captures.
module ripple_chain_ctrl
  import ripple_pkg::*;
#(
  parameter int WIDTH      = 6,
  parameter int CLEAR_CYC  = 2,
  parameter int SETTLE_CYC = 4,
  parameter int MAX_RUN    = 255
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] count_in,
  output logic             chain_en,
  output logic             chain_clr,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic             timeout,
  output logic [WIDTH-1:0] result
);

  localparam logic [CYC_CNT_W-1:0] CLR_LAST    = CYC_CNT_W'(CLEAR_CYC - 1);
  localparam logic [CYC_CNT_W-1:0] SETTLE_LAST = CYC_CNT_W'(SETTLE_CYC - 1);
  localparam logic [RUN_CNT_W-1:0] RUN_LAST    = RUN_CNT_W'(MAX_RUN - 1);

  logic [2:0]           state_r, state_s;
  logic [WIDTH-1:0]     lim_r, lim_s;
  logic [CYC_CNT_W-1:0] clr_cnt_r, clr_cnt_s;
  logic [CYC_CNT_W-1:0] settle_cnt_r, settle_cnt_s;
  logic [RUN_CNT_W-1:0] run_cnt_r, run_cnt_s;
  logic                 hit_r, hit_s;
  logic                 timeout_r, timeout_s;
  logic [WIDTH-1:0]     result_r, result_s;
  logic                 chain_en_r, chain_clr_r, busy_r, done_r;
  logic                 match_s;
  logic                 flush_s;

  assign flush_s = (state_r != RUN);

  ripple_match_filter #(
    .WIDTH (WIDTH)
  ) u_match_filter (
    .clk      (clk),
    .clear    (clear),
    .flush    (flush_s),
    .count_in (count_in),
    .lim      (lim_r),
    .match    (match_s)
  );

  // next-state and session bookkeeping
  always_comb begin
    state_s      = state_r;
    lim_s        = lim_r;
    clr_cnt_s    = clr_cnt_r;
    settle_cnt_s = settle_cnt_r;
    run_cnt_s    = run_cnt_r;
    hit_s        = hit_r;
    timeout_s    = timeout_r;
    result_s     = result_r;
    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          state_s   = CLR;
          lim_s     = limit;
          hit_s     = 1'b0;
          timeout_s = 1'b0;
          clr_cnt_s = {CYC_CNT_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      CLR: begin
        if (abort) begin
          state_s = IDLE;
        end else if (clr_cnt_r == CLR_LAST) begin
          clr_cnt_s = {CYC_CNT_W{1'b0}};
          // a zero limit is already satisfied by the freshly cleared chain
          if (lim_r != {WIDTH{1'b0}}) begin
            state_s   = RUN;
            run_cnt_s = {RUN_CNT_W{1'b0}};
          end else begin
            state_s      = HOLD;
            hit_s        = 1'b1;
            settle_cnt_s = {CYC_CNT_W{1'b0}};
          end
        end else begin
          clr_cnt_s = clr_cnt_r + CYC_CNT_W'(1);
        end
      end
      RUN: begin
        run_cnt_s = run_cnt_r + RUN_CNT_W'(1);
        if (abort) begin
          state_s = IDLE;
        end else if (match_s) begin
          state_s      = HOLD;
          hit_s        = 1'b1;
          settle_cnt_s = {CYC_CNT_W{1'b0}};
        end else if (run_cnt_r == RUN_LAST) begin
          state_s      = HOLD;
          timeout_s    = 1'b1;
          settle_cnt_s = {CYC_CNT_W{1'b0}};
        end else begin
          state_s = RUN;
        end
      end
      HOLD: begin
        if (abort) begin
          state_s = IDLE;
        end else if (settle_cnt_r == SETTLE_LAST) begin
          state_s  = DONE;
          result_s = count_in;
        end else begin
          settle_cnt_s = settle_cnt_r + CYC_CNT_W'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // state, session registers and outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r      <= IDLE;
      lim_r        <= {WIDTH{1'b0}};
      clr_cnt_r    <= {CYC_CNT_W{1'b0}};
      settle_cnt_r <= {CYC_CNT_W{1'b0}};
      run_cnt_r    <= {RUN_CNT_W{1'b0}};
      hit_r        <= 1'b0;
      timeout_r    <= 1'b0;
      result_r     <= {WIDTH{1'b0}};
      chain_en_r   <= 1'b0;
      chain_clr_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      lim_r        <= lim_s;
      clr_cnt_r    <= clr_cnt_s;
      settle_cnt_r <= settle_cnt_s;
      run_cnt_r    <= run_cnt_s;
      hit_r        <= hit_s;
      timeout_r    <= timeout_s;
      result_r     <= result_s;
      chain_en_r   <= (state_s == RUN);
      chain_clr_r  <= (state_s == CLR);
      busy_r       <= (state_s != IDLE);
      done_r       <= (state_s == DONE);
    end
  end

  assign chain_en  = chain_en_r;
  assign chain_clr = chain_clr_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign hit       = hit_r;
  assign timeout   = timeout_r;
  assign result    = result_r;

endmodule

// File: doc/ripple_chain_ctrl.md
Name: ripple_chain_ctrl

Overview:
Sequencer for the 6-stage JK toggle-flip-flop ripple counter chain. It owns the chain's toggle-enable (x) and clear lines. On a start request it clears the chain, enables counting, and watches the chain outputs until they reach a programmed limit. It then stops the chain, waits for the ripple to settle, captures the final count and reports done, or reports timeout if the chain stalls.

Parameters:
WIDTH, 6, number of ripple stages / count bits
CLEAR_CYC, 2, clk cycles chain_clr is held high
SETTLE_CYC, 4, clk cycles waited after chain_en drops before capture
MAX_RUN, 255, RUN-state cycle budget before timeout (8-bit run counter)

Ports:
clk  in  1  single system clock, rising edge
clear  in  1  synchronous, active-high reset
start  in  1  begin a counting session (level sampled each edge)
abort  in  1  cancel session
limit  in  WIDTH  terminal count, latched on accepted start
count_in  in  WIDTH  chain stage outputs, asynchronous to clk
chain_en  out  1  toggle enable to every JK stage (J=K=x)
chain_clr  out  1  active-high clear request to the chain
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse, session complete
hit  out  1  last session ended on limit match
timeout  out  1  last session ended on MAX_RUN expiry
result  out  WIDTH  captured count, held until the next session's DONE

Behaviour:
- All outputs registered. clear=1 at an edge: state IDLE; all outputs 0; lim_q, run_cnt and settle/clear counters 0.
- States: IDLE, CLR, RUN, HOLD, DONE.
- IDLE: chain_en=0, chain_clr=0.
  - start=1 and abort=0 → latch lim_q=limit, clear hit/timeout, go CLR.
  - start with abort in the same cycle → stay IDLE.
- CLR: chain_clr=1, chain_en=0 for exactly CLEAR_CYC cycles.
  - Then go RUN if lim_q≠0.
  - If lim_q=0, go HOLD directly with hit=1.
- RUN: chain_en=1; run_cnt increments each cycle.
  - Match filter: count_in sampled into two pipeline registers; match = both samples equal lim_q. This rejects ripple glitches.
  - match → HOLD, hit=1.
  - Else run_cnt reaches MAX_RUN → HOLD, timeout=1.
  - Match and timeout in the same cycle → hit wins, timeout stays 0.
- HOLD: chain_en=0 from the first HOLD cycle; count SETTLE_CYC cycles, then go DONE.
- DONE: one cycle only. result=count_in (single sample), done=1, busy=1. Next state IDLE.
- Latency: start accepted at edge 0 → chain_clr high cycles 1..CLEAR_CYC → chain_en high from cycle CLEAR_CYC+1.
- Match exit: 2 cycles of filter delay after count_in becomes stable at lim_q, plus the transition edge.
- abort=1 in CLR, RUN or HOLD → next state IDLE. chain_en and chain_clr go 0; no done; result, hit and timeout unchanged.
- abort in DONE is ignored; done still pulses.
- start while busy is ignored; limit changes while busy are ignored.
- clear mid-session: immediate return to reset values at that edge, including chain_en=0.
- The chain counts up mod 2^WIDTH. Comparison is exact equality only, so lim_q is reachable for every WIDTH-bit value.

Decomposition:
- Shared package ripple_pkg:
  - state encoding localparams: IDLE=0, CLR=1, RUN=2, HOLD=3, DONE=4 (3-bit);
  - RUN_CNT_W=8.
- Sub-module ripple_match_filter (two-stage sampler plus equality compare).
  - Ports: clk, clear, flush, count_in, lim, match.
  - flush is asserted while not in RUN, so stale samples never produce a match.

Test Plan:
- Reset: clear=1 for 2 cycles with start=1 → all outputs 0, busy=0, state IDLE.
- Normal session: WIDTH=6, limit=13, behavioural chain model incrementing on chain_en.
  - chain_clr high for exactly 2 cycles, then chain_en high.
  - chain_en drops 3 cycles after model count=13.
  - 4 settle cycles, then done pulse with result=13, hit=1, timeout=0.
- limit=0: start → CLR for 2 cycles, no chain_en ever → done with result=0, hit=1.
- Stalled chain: model frozen at 5, limit=40 → after 255 RUN cycles HOLD, then done with timeout=1, hit=0, result=5.
- Abort: limit=50, assert abort at count≈20 → chain_en=0 next edge, busy=0, no done, result keeps previous session's 13.
- Glitch and contention:
  - inject a single-cycle count_in=limit glitch in RUN → no match (filter needs 2 samples);
  - start+abort together in IDLE → stays IDLE;
  - start during RUN → ignored.
